mem_ctrl: RTL and testbench

Memory controller that shares the single byte-wide RAM/IO port between instruction fetch and the LSU. It arbitrates between the two requesters and sequences multi-byte loads and stores into per-byte RAM cycles. It assembles read data little-endian and returns a one-cycle done pulse to the granted requester. It sits between the LSU/ifetch units and the top-level RAM/IO bus, and honours `rdy_in`, pipeline `clear`, and the IO back-pressure signal.

---
 rtl/mem_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Byte-wide RAM/IO port controller shared by instruction fetch and the LSU.
// Arbitrates, splits multi-byte accesses into byte cycles and assembles reads little-endian.
module mem_ctrl (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        io_buffer_full,
  input  logic        if_en,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_en,
  input  logic        ls_wr,
  input  logic [31:0] ls_addr,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state_q, state_d;
  logic        owner_ls_q, owner_ls_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        if_done_q, if_done_d;
  logic        ls_done_q, ls_done_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;

  logic [31:0] base_q, base_d;
  logic [2:0]  nbytes_q, nbytes_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rbuf_q, rbuf_d;

  logic [31:0] cur_addr;
  logic [31:0] merged;
  logic [1:0]  cap_idx;

  function automatic logic [2:0] size_to_n(input logic [1:0] size);
    case (size)
      2'b00:   size_to_n = 3'd1;
      2'b01:   size_to_n = 3'd2;
      default: size_to_n = 3'd4;
    endcase
  endfunction

  // IO space sits at addr[17:16]==2'b11; its stores wait while the IO buffer is full.
  function automatic logic io_stall(input logic [31:0] addr, input logic full);
    io_stall = (addr[17:16] == 2'b11) && full;
  endfunction

  always_comb begin
    state_d    = state_q;
    owner_ls_d = owner_ls_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    if_done_d  = 1'b0;
    ls_done_d  = 1'b0;
    if_data_d  = if_data_q;
    ls_rdata_d = ls_rdata_q;
    base_d     = base_q;
    nbytes_d   = nbytes_q;
    wdata_d    = wdata_q;
    rbuf_d     = rbuf_q;
    cur_addr   = base_q + {29'd0, cnt_q};
    cap_idx    = cnt_q[1:0] - 2'd2;
    merged     = rbuf_q;

    case (state_q)
      IDLE: begin
        if (!clear && ls_en) begin
          owner_ls_d = 1'b1;
          base_d     = ls_addr;
          nbytes_d   = size_to_n(ls_size);
          wdata_d    = ls_wdata;
          rbuf_d     = 32'd0;
          if (ls_wr) begin
            state_d = WRITE;
            if (io_stall(ls_addr, io_buffer_full)) begin
              wr_d  = 1'b0;
              cnt_d = 3'd0;
            end else begin
              mem_a_d    = ls_addr;
              mem_dout_d = ls_wdata[7:0];
              wr_d       = 1'b1;
              cnt_d      = 3'd1;
            end
          end else begin
            state_d = READ;
            mem_a_d = ls_addr;
            cnt_d   = 3'd1;
          end
        end else if (!clear && if_en) begin
          owner_ls_d = 1'b0;
          base_d     = if_addr;
          nbytes_d   = 3'd4;
          rbuf_d     = 32'd0;
          state_d    = READ;
          mem_a_d    = if_addr;
          cnt_d      = 3'd1;
        end
      end

      READ: begin
        if (clear) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else begin
          // cnt counts edges since grant; the RAM returns byte i two edges after issue.
          if (cnt_q < nbytes_q) mem_a_d = cur_addr;
          if (cnt_q >= 3'd2) merged[{cap_idx, 3'b000} +: 8] = mem_din;
          rbuf_d = merged;
          if (cnt_q == nbytes_q + 3'd1) begin
            state_d = DONE;
            cnt_d   = 3'd0;
            if (owner_ls_q) begin
              ls_done_d  = 1'b1;
              ls_rdata_d = merged;
            end else begin
              if_done_d = 1'b1;
              if_data_d = merged;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      WRITE: begin
        if (cnt_q == nbytes_q) begin
          state_d   = DONE;
          wr_d      = 1'b0;
          cnt_d     = 3'd0;
          ls_done_d = 1'b1;
        end else if (io_stall(cur_addr, io_buffer_full)) begin
          wr_d = 1'b0;
        end else begin
          mem_a_d    = cur_addr;
          mem_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
          wr_d       = 1'b1;
          cnt_d      = cnt_q + 3'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      owner_ls_q <= 1'b0;
      cnt_q      <= 3'd0;
      wr_q       <= 1'b0;
      mem_a_q    <= 32'd0;
      mem_dout_q <= 8'd0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      if_data_q  <= 32'd0;
      ls_rdata_q <= 32'd0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      owner_ls_q <= owner_ls_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      if_done_q  <= if_done_d;
      ls_done_q  <= ls_done_d;
      if_data_q  <= if_data_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      base_q   <= base_d;
      nbytes_q <= nbytes_d;
      wdata_q  <= wdata_d;
      rbuf_q   <= rbuf_d;
    end
  end

  assign if_done  = if_done_q;
  assign if_data  = if_data_q;
  assign ls_done  = ls_done_q;
  assign ls_rdata = ls_rdata_q;
  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_wr   = wr_q & rdy_in;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a synchronous byte RAM model.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear, io_buffer_full;
  logic        if_en;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_en, ls_wr;
  logic [31:0] ls_addr;
  logic [1:0]  ls_size;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic [7:0]  mem_din = 8'd0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  int n_tests = 0;
  int n_fail  = 0;

  mem_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .io_buffer_full(io_buffer_full),
    .if_en(if_en), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_en(ls_en), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_size(ls_size),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] rom_byte(input logic [31:0] a);
    case (a)
      32'h1000: rom_byte = 8'h13;
      32'h1001: rom_byte = 8'h05;
      32'h1002: rom_byte = 8'h10;
      32'h1003: rom_byte = 8'h00;
      32'h2000: rom_byte = 8'hF0;
      default:  rom_byte = 8'h00;
    endcase
  endfunction

  // RAM read port is clock-enabled by rdy_in like the rest of the system.
  always @(posedge clk_in) begin
    if (rdy_in) mem_din <= rom_byte(mem_a);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic bus(input string tag, input logic [31:0] a, input logic [7:0] d, input logic w);
    chk({tag, "_a"}, mem_a, a);
    if (w) chk({tag, "_d"}, {24'd0, mem_dout}, {24'd0, d});
    chk({tag, "_wr"}, {31'd0, mem_wr}, {31'd0, w});
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
    if_en = 1'b0; if_addr = 32'h0;
    ls_en = 1'b0; ls_wr = 1'b0; ls_addr = 32'h0; ls_size = 2'b00; ls_wdata = 32'h0;
    step(); step();
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_if_done", {31'd0, if_done}, 32'd0);
    chk("rst_ls_done", {31'd0, ls_done}, 32'd0);
    chk("rst_if_data", if_data, 32'h0);
    chk("rst_ls_rdata", ls_rdata, 32'h0);
    rst_in = 1'b0;
    step();

    // Word fetch
    if_en = 1'b1; if_addr = 32'h1000;
    step(); bus("f_p0", 32'h1000, 8'h0, 1'b0);
    step(); bus("f_p1", 32'h1001, 8'h0, 1'b0);
    step(); bus("f_p2", 32'h1002, 8'h0, 1'b0);
    step(); bus("f_p3", 32'h1003, 8'h0, 1'b0);
    step(); chk("f_p4_done", {31'd0, if_done}, 32'd0);
    step(); chk("f_p5_done", {31'd0, if_done}, 32'd1);
    chk("f_p5_data", if_data, 32'h00100513);
    if_en = 1'b0;
    step(); chk("f_p6_done", {31'd0, if_done}, 32'd0);

    // Simultaneous requests: LSU byte load wins
    ls_en = 1'b1; ls_wr = 1'b0; ls_addr = 32'h2000; ls_size = 2'b00;
    if_en = 1'b1; if_addr = 32'h1000;
    step(); chk("arb_p0_a", mem_a, 32'h2000);
    step(); chk("arb_p1_done", {31'd0, ls_done}, 32'd0);
    step(); chk("arb_p2_done", {31'd0, ls_done}, 32'd1);
    chk("arb_p2_rdata", ls_rdata, 32'h000000F0);
    chk("arb_p2_ifdone", {31'd0, if_done}, 32'd0);
    ls_en = 1'b0;
    step(); chk("arb_p3_a", mem_a, 32'h2000);
    step(); chk("arb_p4_fetch_a", mem_a, 32'h1000);
    for (int i = 0; i < 5; i++) step();
    chk("arb_p9_ifdone", {31'd0, if_done}, 32'd1);
    chk("arb_p9_ifdata", if_data, 32'h00100513);
    if_en = 1'b0;
    step();

    // Half store
    ls_en = 1'b1; ls_wr = 1'b1; ls_addr = 32'h2002; ls_size = 2'b01; ls_wdata = 32'h0000BEEF;
    step(); bus("sh_p0", 32'h2002, 8'hEF, 1'b1);
    step(); bus("sh_p1", 32'h2003, 8'hBE, 1'b1);
    step(); chk("sh_p2_done", {31'd0, ls_done}, 32'd1);
    chk("sh_p2_wr", {31'd0, mem_wr}, 32'd0);
    ls_en = 1'b0;
    step(); chk("sh_p3_wr", {31'd0, mem_wr}, 32'd0);

    // IO store stalled by a full buffer
    ls_en = 1'b1; ls_wr = 1'b1; ls_addr = 32'h30000; ls_size = 2'b00; ls_wdata = 32'h41;
    io_buffer_full = 1'b1;
    step(); chk("io_p0_wr", {31'd0, mem_wr}, 32'd0);
    step(); chk("io_p1_wr", {31'd0, mem_wr}, 32'd0);
    step(); chk("io_p2_wr", {31'd0, mem_wr}, 32'd0);
    io_buffer_full = 1'b0;
    step(); bus("io_p3", 32'h30000, 8'h41, 1'b1);
    chk("io_p3_done", {31'd0, ls_done}, 32'd0);
    step(); chk("io_p4_done", {31'd0, ls_done}, 32'd1);
    ls_en = 1'b0;
    step();

    // Clear during fetch aborts it; the controller accepts a new request right after
    if_en = 1'b1; if_addr = 32'h1000;
    step(); step();
    clear = 1'b1; if_en = 1'b0;
    step();
    clear = 1'b0;
    ls_en = 1'b1; ls_wr = 1'b0; ls_addr = 32'h2000; ls_size = 2'b00;
    chk("clr_p2_ifdone", {31'd0, if_done}, 32'd0);
    step(); chk("clr_regrant_a", mem_a, 32'h2000);
    chk("clr_p3_ifdone", {31'd0, if_done}, 32'd0);
    step(); chk("clr_p4_ifdone", {31'd0, if_done}, 32'd0);
    step(); chk("clr_ld_done", {31'd0, ls_done}, 32'd1);
    chk("clr_ld_rdata", ls_rdata, 32'h000000F0);
    ls_en = 1'b0;
    step();

    // Clear during word store is ignored
    ls_en = 1'b1; ls_wr = 1'b1; ls_addr = 32'h2010; ls_size = 2'b10; ls_wdata = 32'h11223344;
    step(); bus("cw_p0", 32'h2010, 8'h44, 1'b1);
    clear = 1'b1;
    step(); bus("cw_p1", 32'h2011, 8'h33, 1'b1);
    step(); bus("cw_p2", 32'h2012, 8'h22, 1'b1);
    clear = 1'b0;
    step(); bus("cw_p3", 32'h2013, 8'h11, 1'b1);
    step(); chk("cw_p4_done", {31'd0, ls_done}, 32'd1);
    ls_en = 1'b0;
    step();

    // rdy_in low for 2 cycles mid-fetch delays done by 2
    if_en = 1'b1; if_addr = 32'h1000;
    step(); step();
    rdy_in = 1'b0;
    step(); chk("rdy_frz1_a", mem_a, 32'h1001);
    chk("rdy_frz1_wr", {31'd0, mem_wr}, 32'd0);
    step(); chk("rdy_frz2_a", mem_a, 32'h1001);
    rdy_in = 1'b1;
    step(); chk("rdy_p4_a", mem_a, 32'h1002);
    step(); chk("rdy_p5_a", mem_a, 32'h1003);
    chk("rdy_p5_done", {31'd0, if_done}, 32'd0);
    step(); chk("rdy_p6_done", {31'd0, if_done}, 32'd0);
    step(); chk("rdy_p7_done", {31'd0, if_done}, 32'd1);
    chk("rdy_p7_data", if_data, 32'h00100513);
    if_en = 1'b0;
    step();

    // rdy_in low forces mem_wr low during a store byte
    ls_en = 1'b1; ls_wr = 1'b1; ls_addr = 32'h2020; ls_size = 2'b00; ls_wdata = 32'h5A;
    step(); bus("rw_p0", 32'h2020, 8'h5A, 1'b1);
    rdy_in = 1'b0;
    #1 chk("rw_frz_wr", {31'd0, mem_wr}, 32'd0);
    step(); chk("rw_frz_a", mem_a, 32'h2020);
    chk("rw_frz_done", {31'd0, ls_done}, 32'd0);
    rdy_in = 1'b1;
    step(); chk("rw_done", {31'd0, ls_done}, 32'd1);
    ls_en = 1'b0;
    step();

    // Reset mid word store
    ls_en = 1'b1; ls_wr = 1'b1; ls_addr = 32'h2030; ls_size = 2'b10; ls_wdata = 32'hCAFEBABE;
    step(); bus("rs_p0", 32'h2030, 8'hBE, 1'b1);
    rst_in = 1'b1;
    step();
    chk("rs_a", mem_a, 32'h0);
    chk("rs_dout", {24'd0, mem_dout}, 32'h0);
    chk("rs_wr", {31'd0, mem_wr}, 32'd0);
    chk("rs_done", {31'd0, ls_done}, 32'd0);
    rst_in = 1'b0; ls_en = 1'b0;
    if_en = 1'b1; if_addr = 32'h1000;
    step(); chk("rs_regrant_a", mem_a, 32'h1000);
    chk("rs_regrant_wr", {31'd0, mem_wr}, 32'd0);
    for (int i = 0; i < 5; i++) step();
    chk("rs_fetch_done", {31'd0, if_done}, 32'd1);
    if_en = 1'b0;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
